// File: rtl/lstm_bp_pkg.sv
// Shared FSM encoding and saturation limits for the LSTM backprop parameter-update datapath.
package lstm_bp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT   = 3'd2,
    UPDATE = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } upd_state_t;

  localparam int SAT_W = 32;
  localparam logic signed [SAT_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [SAT_W-1:0] SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: full 2*WIDTH product, arithmetic shift right by FRAC,
// then clamped back into WIDTH bits.
module fxp_mul_sat
  import lstm_bp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] MAXV = (WIDTH == SAT_W) ? SAT_MAX : {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = (WIDTH == SAT_W) ? SAT_MIN : {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    MAXP = PW'(MAXV);
  localparam logic signed [PW-1:0]    MINP = PW'(MINV);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  // Compare the shifted product at full width so large results clamp instead of wrapping
  always_comb begin
    prod    = PW'(a) * PW'(b);
    shifted = prod >>> FRAC;
    if (shifted > MAXP)      y = MAXV;
    else if (shifted < MINP) y = MINV;
    else                     y = shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/dparam_update.sv
// Accumulates dgate*act over NUM_STEP timesteps per parameter and writes w - lr*g back.
// Define GRAD_CLIP_EN to clamp the accumulated gradient to [-CLIP, +CLIP] before scaling.
module dparam_update
  import lstm_bp_pkg::*;
#(
  parameter int                 WIDTH     = 32,
  parameter int                 FRAC      = 24,
  parameter int                 NUM_STEP  = 8,
  parameter int                 NUM_PARAM = 53,
  parameter int                 STEP_W    = 4,
  parameter int                 IDX_W     = 9,
  parameter logic signed [WIDTH-1:0] CLIP = 32'sh0100_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  lr,
  output logic                     rd_en,
  output logic [STEP_W-1:0]        o_step,
  output logic [IDX_W-1:0]         o_idx,
  input  logic signed [WIDTH-1:0]  i_dgate,
  input  logic signed [WIDTH-1:0]  i_act,
  input  logic signed [WIDTH-1:0]  i_w,
  output logic                     wr_en,
  output logic signed [WIDTH-1:0]  wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic signed [WIDTH-1:0] MAXV = (WIDTH == SAT_W) ? SAT_MAX : {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = (WIDTH == SAT_W) ? SAT_MIN : {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_CLIP  = -CLIP;
  localparam logic [STEP_W-1:0]       LAST_STEP = STEP_W'(NUM_STEP - 1);
  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_PARAM - 1);

`ifdef GRAD_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  upd_state_t state;
  upd_state_t state_nxt;

  logic [STEP_W-1:0]       step_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    rd_q;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] new_w;
  logic signed [WIDTH-1:0] prod_g;
  logic signed [WIDTH-1:0] g_use;
  logic signed [WIDTH-1:0] lr_g;
  logic signed [WIDTH-1:0] acc_sum;
  logic signed [WIDTH-1:0] upd_val;

  // Operands are sign-extended by one bit; a carry differing from the sign means overflow
  function automatic logic signed [WIDTH-1:0] sat_fit(input logic [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MINV : MAXV;
    return s[WIDTH-1:0];
  endfunction

  fxp_mul_sat #(
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) u_grad_mul (
    .a(i_dgate),
    .b(i_act),
    .y(prod_g)
  );

  fxp_mul_sat #(
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) u_lr_mul (
    .a(lr),
    .b(g_use),
    .y(lr_g)
  );

  always_comb begin
    g_use = acc;
    if (CLIP_ON) begin
      if (acc > CLIP)          g_use = CLIP;
      else if (acc < NEG_CLIP) g_use = NEG_CLIP;
    end
  end

  assign acc_sum = sat_fit({acc[WIDTH-1], acc} + {prod_g[WIDTH-1], prod_g});
  assign upd_val = sat_fit({i_w[WIDTH-1], i_w} - {lr_g[WIDTH-1], lr_g});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (step_q == LAST_STEP) state_nxt = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        state_nxt = UPDATE;
      end
      UPDATE: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        wr_en     = 1'b1;
        state_nxt = (idx_q < LAST_IDX) ? READ : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data lands one cycle after rd_en, so rd_q marks the cycles that carry a sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= '0;
      idx_q  <= '0;
      rd_q   <= 1'b0;
      acc    <= '0;
      new_w  <= '0;
    end else begin
      rd_q <= rd_en;
      if (rd_q) acc <= acc_sum;
      case (state)
        IDLE: begin
          if (start) begin
            idx_q  <= '0;
            step_q <= '0;
            acc    <= '0;
          end
        end
        READ: begin
          step_q <= (step_q == LAST_STEP) ? '0 : step_q + 1'b1;
        end
        UPDATE: begin
          new_w <= upd_val;
        end
        WRITE: begin
          if (idx_q < LAST_IDX) begin
            idx_q <= idx_q + 1'b1;
            acc   <= '0;
          end
        end
        DONE: begin
          idx_q <= '0;
          acc   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_step  = step_q;
  assign o_idx   = idx_q;
  assign wr_data = new_w;

endmodule

// File: tb/tb_dparam_update.sv
// Scoreboard bench for dparam_update: a memory model answers rd_en, expected writes are
// queued at start and popped as wr_en appears.
module tb_dparam_update;

  localparam int W      = 32;
  localparam int NS     = 2;
  localparam int NP     = 5;
  localparam int STEP_W = 4;
  localparam int IDX_W  = 9;
  localparam int RUN_CYC = NP * (NS + 3) + 1;
  localparam logic signed [31:0] ONE  = 32'sh0100_0000;
  localparam logic signed [31:0] SMAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SMIN = 32'sh8000_0000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic signed [W-1:0]  lr = '0;
  logic                 rd_en;
  logic [STEP_W-1:0]    o_step;
  logic [IDX_W-1:0]     o_idx;
  logic signed [W-1:0]  i_dgate = '0;
  logic signed [W-1:0]  i_act = '0;
  logic signed [W-1:0]  i_w = '0;
  logic                 wr_en;
  logic signed [W-1:0]  wr_data;
  logic                 busy;
  logic                 done;

  dparam_update #(
    .WIDTH(W), .FRAC(24), .NUM_STEP(NS), .NUM_PARAM(NP),
    .STEP_W(STEP_W), .IDX_W(IDX_W), .CLIP(ONE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lr(lr),
    .rd_en(rd_en), .o_step(o_step), .o_idx(o_idx),
    .i_dgate(i_dgate), .i_act(i_act), .i_w(i_w),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic signed [31:0] dgate_mem [NP][NS];
  logic signed [31:0] act_mem   [NP][NS];
  logic signed [31:0] w_mem     [NP];

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: data for an rd_en cycle appears just after the following edge; junk otherwise
  initial begin : mem_model
    bit en;
    int ci, cs;
    forever begin
      @(negedge clk);
      en = rd_en;
      ci = int'(o_idx);
      cs = int'(o_step);
      i_w = (ci < NP) ? w_mem[ci] : $signed($urandom);
      @(posedge clk);
      #1;
      if (en && ci < NP && cs < NS) begin
        i_dgate = dgate_mem[ci][cs];
        i_act   = act_mem[ci][cs];
      end else begin
        i_dgate = $signed($urandom);
        i_act   = $signed($urandom);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic signed [31:0] sat32(input longint v);
    if (v > 64'sh0000_0000_7FFF_FFFF) return SMAX;
    if (v < -64'sh0000_0000_8000_0000) return SMIN;
    return v[31:0];
  endfunction

  function automatic logic signed [31:0] mulq(input logic signed [31:0] a, input logic signed [31:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return sat32(p >>> 24);
  endfunction

  function automatic logic signed [31:0] exp_for(input int i);
    longint g;
    logic signed [31:0] g32;
    g = 0;
    for (int s = 0; s < NS; s++) g = sat32(g + longint'(mulq(dgate_mem[i][s], act_mem[i][s])));
`ifdef GRAD_CLIP_EN
    if (g > 64'sh0100_0000) g = 64'sh0100_0000;
    if (g < -64'sh0100_0000) g = -64'sh0100_0000;
`endif
    g32 = g[31:0];
    return sat32(longint'(w_mem[i]) - longint'(mulq(lr, g32)));
  endfunction

  function automatic logic signed [31:0] rnd_small();
    return $signed($urandom_range(32'h0400_0000, 0)) - 32'sh0200_0000;
  endfunction

  task automatic push_model();
    for (int i = 0; i < NP; i++) sbq.push_back('{idx: i, data: exp_for(i)});
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rd_en, wr_en, busy, done} !== 4'b0) begin
      n_fail++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {rd_en, wr_en, busy, done});
    end
    n_checks++;
    if ({o_step, o_idx} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_addr: got step %0d idx %0d expected 0 0", o_step, o_idx);
    end
    n_checks++;
    if (wr_data !== '0) begin
      n_fail++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rd_en, busy, done} !== 3'b0) begin
      n_fail++; $display("[TB] FAIL idle_no_start: got %b expected 000", {rd_en, busy, done});
    end
  endtask

  task automatic test_timing();
    bit seen = 0;
    exp_t e;
    lr = 32'sh0080_0000;
    for (int i = 0; i < NP; i++) begin
      w_mem[i] = ONE;
      for (int s = 0; s < NS; s++) begin dgate_mem[i][s] = ONE; act_mem[i][s] = ONE; end
    end
    for (int i = 0; i < NP; i++) sbq.push_back('{idx: i, data: 32'h0000_0000});
    launch();
    for (int c = 1; c <= RUN_CYC + 10 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL timing_busy: got %b expected 1", busy); end
      end
      if (c <= NS + 3) begin
        n_checks++;
        if (rd_en !== (c <= NS)) begin n_fail++; $display("[TB] FAIL timing_rd_en c%0d: got %b expected %b", c, rd_en, c <= NS); end
        n_checks++;
        if (wr_en !== (c == NS + 3)) begin n_fail++; $display("[TB] FAIL timing_wr_en c%0d: got %b expected %b", c, wr_en, c == NS + 3); end
        n_checks++;
        if (o_idx !== '0) begin n_fail++; $display("[TB] FAIL timing_idx c%0d: got %0d expected 0", c, o_idx); end
        if (c <= NS) begin
          n_checks++;
          if (o_step !== STEP_W'(c - 1)) begin n_fail++; $display("[TB] FAIL timing_step c%0d: got %0d expected %0d", c, o_step, c - 1); end
        end
      end
      if (wr_en) begin
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL timing_extra_write: got idx %0d expected none", o_idx); end
        else begin
          e = sbq.pop_front();
          if (int'(o_idx) !== e.idx || wr_data !== e.data) begin
            n_fail++; $display("[TB] FAIL timing_write: got idx %0d data %h expected idx %0d data %h", o_idx, wr_data, e.idx, e.data);
          end
        end
      end
      if (done) begin
        seen = 1;
        n_checks++;
        if (c != RUN_CYC) begin n_fail++; $display("[TB] FAIL timing_done_cycle: got %0d expected %0d", c, RUN_CYC); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL timing_busy_at_done: got %b expected 0", busy); end
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("[TB] FAIL timing_timeout: got no done expected done at %0d", RUN_CYC); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL timing_done_pulse: got %b expected 0", done); end
    n_checks++;
    if (sbq.size() != 0) begin n_fail++; $display("[TB] FAIL timing_missing_writes: got %0d left expected 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_lr_zero();
    bit seen = 0;
    exp_t e;
    lr = '0;
    for (int i = 0; i < NP; i++) begin
      w_mem[i] = $signed($urandom);
      for (int s = 0; s < NS; s++) begin
        dgate_mem[i][s] = $signed($urandom);
        act_mem[i][s]   = $signed($urandom);
      end
      sbq.push_back('{idx: i, data: w_mem[i]});
    end
    launch();
    for (int c = 1; c <= RUN_CYC + 10 && !seen; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_idx > IDX_W'(NP - 1)) begin n_fail++; $display("[TB] FAIL lr0_idx_range: got %0d expected <= %0d", o_idx, NP - 1); end
      if (wr_en) begin
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL lr0_extra_write: got idx %0d expected none", o_idx); end
        else begin
          e = sbq.pop_front();
          if (int'(o_idx) !== e.idx || wr_data !== e.data) begin
            n_fail++; $display("[TB] FAIL lr0_write: got idx %0d data %h expected idx %0d data %h", o_idx, wr_data, e.idx, e.data);
          end
        end
      end
      if (done) seen = 1;
    end
    n_checks++;
    if (!seen || sbq.size() != 0) begin n_fail++; $display("[TB] FAIL lr0_completion: got done %b left %0d expected done 1 left 0", seen, sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_saturation();
    bit seen = 0;
    exp_t e;
    lr = ONE;
    for (int i = 0; i < NP; i++) begin
      for (int s = 0; s < NS; s++) begin
        dgate_mem[i][s] = SMAX;
        act_mem[i][s]   = (i % 2 == 0) ? SMAX : SMIN;
      end
      w_mem[i] = (i % 2 == 0) ? SMIN : SMAX;
      sbq.push_back('{idx: i, data: (i % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF});
    end
    launch();
    for (int c = 1; c <= RUN_CYC + 10 && !seen; c++) begin
      @(negedge clk);
      if (wr_en) begin
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL sat_extra_write: got idx %0d expected none", o_idx); end
        else begin
          e = sbq.pop_front();
          if (int'(o_idx) !== e.idx || wr_data !== e.data) begin
            n_fail++; $display("[TB] FAIL sat_write: got idx %0d data %h expected idx %0d data %h", o_idx, wr_data, e.idx, e.data);
          end
        end
      end
      if (done) seen = 1;
    end
    n_checks++;
    if (!seen || sbq.size() != 0) begin n_fail++; $display("[TB] FAIL sat_completion: got done %b left %0d expected done 1 left 0", seen, sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_clip();
    bit seen = 0;
    exp_t e;
    logic [31:0] pos_exp, neg_exp;
`ifdef GRAD_CLIP_EN
    pos_exp = 32'hFF00_0000;
    neg_exp = 32'h0100_0000;
`else
    pos_exp = 32'hFD00_0000;
    neg_exp = 32'h0300_0000;
`endif
    lr = ONE;
    for (int i = 0; i < NP; i++) begin
      dgate_mem[i][0] = (i % 2 == 0) ? 32'sh0200_0000 : -32'sh0200_0000;
      dgate_mem[i][1] = (i % 2 == 0) ? ONE : -ONE;
      act_mem[i][0]   = ONE;
      act_mem[i][1]   = ONE;
      w_mem[i]        = '0;
      sbq.push_back('{idx: i, data: (i % 2 == 0) ? pos_exp : neg_exp});
    end
    launch();
    for (int c = 1; c <= RUN_CYC + 10 && !seen; c++) begin
      @(negedge clk);
      if (wr_en) begin
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL clip_extra_write: got idx %0d expected none", o_idx); end
        else begin
          e = sbq.pop_front();
          if (int'(o_idx) !== e.idx || wr_data !== e.data) begin
            n_fail++; $display("[TB] FAIL clip_write: got idx %0d data %h expected idx %0d data %h", o_idx, wr_data, e.idx, e.data);
          end
        end
      end
      if (done) seen = 1;
    end
    n_checks++;
    if (!seen || sbq.size() != 0) begin n_fail++; $display("[TB] FAIL clip_completion: got done %b left %0d expected done 1 left 0", seen, sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_random();
    bit seen = 0;
    exp_t e;
    lr = rnd_small();
    for (int i = 0; i < NP; i++) begin
      w_mem[i] = $signed($urandom);
      for (int s = 0; s < NS; s++) begin
        dgate_mem[i][s] = (i % 2 == 0) ? $signed($urandom) : rnd_small();
        act_mem[i][s]   = (i % 2 == 0) ? $signed($urandom) : rnd_small();
      end
    end
    push_model();
    launch();
    for (int c = 1; c <= RUN_CYC + 10 && !seen; c++) begin
      @(negedge clk);
      if (wr_en) begin
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL rand_extra_write: got idx %0d expected none", o_idx); end
        else begin
          e = sbq.pop_front();
          if (int'(o_idx) !== e.idx || wr_data !== e.data) begin
            n_fail++; $display("[TB] FAIL rand_write: got idx %0d data %h expected idx %0d data %h", o_idx, wr_data, e.idx, e.data);
          end
        end
      end
      if (done) seen = 1;
    end
    n_checks++;
    if (!seen || sbq.size() != 0) begin n_fail++; $display("[TB] FAIL rand_completion: got done %b left %0d expected done 1 left 0", seen, sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    exp_t e;
    lr = rnd_small();
    for (int i = 0; i < NP; i++) begin
      w_mem[i] = rnd_small();
      for (int s = 0; s < NS; s++) begin dgate_mem[i][s] = rnd_small(); act_mem[i][s] = rnd_small(); end
    end
    push_model();
    launch();
    for (int c = 1; c <= RUN_CYC + 10 && !seen; c++) begin
      @(negedge clk);
      start = (c == 7 || c == 12 || c == RUN_CYC);
      if (wr_en) begin
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL b2b_extra_write: got idx %0d expected none", o_idx); end
        else begin
          e = sbq.pop_front();
          if (int'(o_idx) !== e.idx || wr_data !== e.data) begin
            n_fail++; $display("[TB] FAIL b2b_write: got idx %0d data %h expected idx %0d data %h", o_idx, wr_data, e.idx, e.data);
          end
        end
      end
      if (done) begin
        seen = 1;
        n_checks++;
        if (c != RUN_CYC) begin n_fail++; $display("[TB] FAIL b2b_done_cycle: got %0d expected %0d", c, RUN_CYC); end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_en, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_start_in_done_ignored: got rd_en/busy %b expected 00", {rd_en, busy}); end
    end
    n_checks++;
    if (!seen || sbq.size() != 0) begin n_fail++; $display("[TB] FAIL b2b_completion: got done %b left %0d expected done 1 left 0", seen, sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_reset_midrun();
    bit hit = 0;
    bit seen = 0;
    exp_t e;
    lr = rnd_small();
    for (int i = 0; i < NP; i++) begin
      w_mem[i] = rnd_small();
      for (int s = 0; s < NS; s++) begin dgate_mem[i][s] = rnd_small(); act_mem[i][s] = rnd_small(); end
    end
    push_model();
    launch();
    for (int c = 1; c <= RUN_CYC && !hit; c++) begin
      @(negedge clk);
      if (wr_en) begin
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL midrst_extra_write: got idx %0d expected none", o_idx); end
        else begin
          e = sbq.pop_front();
          if (int'(o_idx) !== e.idx || wr_data !== e.data) begin
            n_fail++; $display("[TB] FAIL midrst_write: got idx %0d data %h expected idx %0d data %h", o_idx, wr_data, e.idx, e.data);
          end
        end
      end
      if (rd_en && o_idx == IDX_W'(3)) hit = 1;
      else start = (c == 2 || c == 9);
    end
    start = 1'b0;
    n_checks++;
    if (!hit) begin n_fail++; $display("[TB] FAIL midrst_reach_idx3: got no READ at idx 3 expected one"); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({rd_en, wr_en, busy, done, o_step, o_idx, wr_data} !== '0) begin
      n_fail++; $display("[TB] FAIL midrst_outputs_zero: got rd %b wr %b busy %b done %b step %0d idx %0d data %h expected all 0",
                         rd_en, wr_en, busy, done, o_step, o_idx, wr_data);
    end
    sbq.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = (c == 1);
      n_checks++;
      if ({wr_en, done, busy} !== 3'b0) begin n_fail++; $display("[TB] FAIL midrst_held: got wr/done/busy %b expected 000", {wr_en, done, busy}); end
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({wr_en, done, rd_en} !== 3'b0) begin n_fail++; $display("[TB] FAIL midrst_quiet: got wr/done/rd %b expected 000", {wr_en, done, rd_en}); end
    end
    push_model();
    launch();
    for (int c = 1; c <= RUN_CYC + 10 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (o_idx !== '0 || rd_en !== 1'b1 || o_step !== '0) begin
          n_fail++; $display("[TB] FAIL midrst_restart: got idx %0d rd %b step %0d expected 0 1 0", o_idx, rd_en, o_step);
        end
      end
      if (wr_en) begin
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL restart_extra_write: got idx %0d expected none", o_idx); end
        else begin
          e = sbq.pop_front();
          if (int'(o_idx) !== e.idx || wr_data !== e.data) begin
            n_fail++; $display("[TB] FAIL restart_write: got idx %0d data %h expected idx %0d data %h", o_idx, wr_data, e.idx, e.data);
          end
        end
      end
      if (done) begin
        seen = 1;
        n_checks++;
        if (c != RUN_CYC) begin n_fail++; $display("[TB] FAIL restart_done_cycle: got %0d expected %0d", c, RUN_CYC); end
      end
    end
    n_checks++;
    if (!seen || sbq.size() != 0) begin n_fail++; $display("[TB] FAIL restart_completion: got done %b left %0d expected done 1 left 0", seen, sbq.size()); end
    sbq.delete();
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      w_mem[i] = '0;
      for (int s = 0; s < NS; s++) begin dgate_mem[i][s] = '0; act_mem[i][s] = '0; end
    end
    test_reset();
    test_timing();
    test_lr_zero();
    test_saturation();
    test_clip();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
